// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core memory arbiter: default sizes,
// ld/st enable encodings and small helpers.
package core_mem_arbiter_pkg;

  localparam int NUM_CORES_DEF     = 4;
  localparam int REG_WIDTH_DEF     = 8;
  localparam int CORE_ID_WIDTH_DEF = 2;
  localparam int ADDR_WIDTH_DEF    = CORE_ID_WIDTH_DEF + REG_WIDTH_DEF;

  // Per-core enable field; EN_BAD (both bits set) is never a request.
  typedef enum logic [1:0] {
    EN_NONE = 2'b00,
    EN_LD   = 2'b01,
    EN_ST   = 2'b10,
    EN_BAD  = 2'b11
  } enable_e;

  // True only for a genuine ld or st encoding.
  function automatic logic is_access(input logic [1:0] en);
    return (en == EN_LD) || (en == EN_ST);
  endfunction

  // Width of a core index, at least one bit even for a single core.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the per-core request/response buses and the SRAM port.
// The arbiter sits on the slave side; cores plus SRAM sit on the master side.
interface core_mem_arbiter_if
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = NUM_CORES_DEF,
  parameter int REG_WIDTH     = REG_WIDTH_DEF,
  parameter int CORE_ID_WIDTH = CORE_ID_WIDTH_DEF,
  parameter int ADDR_WIDTH    = CORE_ID_WIDTH + REG_WIDTH
) ();

  logic [2*NUM_CORES-1:0]          enable_M;
  logic [ADDR_WIDTH*NUM_CORES-1:0] addr_M;
  logic [REG_WIDTH*NUM_CORES-1:0]  wr_data_M;
  logic [NUM_CORES-1:0]            ready_M;
  logic [REG_WIDTH*NUM_CORES-1:0]  rd_data_M;

  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_we;
  logic                            mem_re;
  logic [REG_WIDTH-1:0]            mem_wr_data;
  logic [REG_WIDTH-1:0]            mem_rd_data;

  modport slave (
    input  enable_M, addr_M, wr_data_M, mem_rd_data,
    output ready_M, rd_data_M, mem_addr, mem_we, mem_re, mem_wr_data
  );

  modport master (
    output enable_M, addr_M, wr_data_M, mem_rd_data,
    input  ready_M, rd_data_M, mem_addr, mem_we, mem_re, mem_wr_data
  );

endinterface

// File: rtl/core_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from rr_ptr+1 upward
// (wrapping) and grants the first requesting core.
module core_mem_arbiter_rr_picker
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  localparam int IDX_W    = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 grant_valid,
  output logic [NUM_CORES-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the cores in priority order; the last-granted core is visited last.
  always_comb begin
    grant_valid  = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_CORES;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid            = 1'b1;
        grant_idx              = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shared data-memory front end: one round-robin grant per cycle onto a
// single-port SRAM with one-cycle read latency, ack returned the next cycle.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = NUM_CORES_DEF,
  parameter int REG_WIDTH     = REG_WIDTH_DEF,
  parameter int CORE_ID_WIDTH = CORE_ID_WIDTH_DEF,
  parameter int ADDR_WIDTH    = CORE_ID_WIDTH + REG_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  core_mem_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_CORES);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant_onehot;
  logic                 grant_valid;
  logic                 grant_fire;
  logic [IDX_W-1:0]     grant_idx;
  logic [1:0]           grant_en;

  logic [IDX_W-1:0]     rr_ptr;
  logic                 resp_valid;
  logic [IDX_W-1:0]     resp_idx;
  logic                 resp_is_ld;

  // A core being answered this cycle still shows its old request, so mask it.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i] = is_access(bus.enable_M[2*i +: 2]) &
               ~(resp_valid && (resp_idx == IDX_W'(i)));
    end
  end

  core_mem_arbiter_rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_picker (
    .req          (req),
    .rr_ptr       (rr_ptr),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign grant_fire = grant_valid & ~reset;

  // Steer the granted core's request onto the SRAM port; idle drives zeros.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    grant_en        = EN_NONE;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_fire && grant_onehot[i]) begin
        bus.mem_addr    = bus.addr_M[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wr_data = bus.wr_data_M[i*REG_WIDTH +: REG_WIDTH];
        grant_en        = bus.enable_M[2*i +: 2];
      end
    end
    bus.mem_we = (grant_en == EN_ST);
    bus.mem_re = (grant_en == EN_LD);
  end

  // Remember who was granted so the ack and read data go back next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= IDX_W'(NUM_CORES - 1);
      resp_valid <= 1'b0;
      resp_idx   <= '0;
      resp_is_ld <= 1'b0;
    end else if (grant_valid) begin
      rr_ptr     <= grant_idx;
      resp_valid <= 1'b1;
      resp_idx   <= grant_idx;
      resp_is_ld <= bus.mem_re;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  // Pulse ready on the answered lane; only loads carry SRAM data back.
  always_comb begin
    bus.ready_M   = '0;
    bus.rd_data_M = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (resp_valid && !reset && (resp_idx == IDX_W'(i))) begin
        bus.ready_M[i] = 1'b1;
        if (resp_is_ld) begin
          bus.rd_data_M[i*REG_WIDTH +: REG_WIDTH] = bus.mem_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with a behavioural single-port SRAM.
module tb_core_mem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  core_mem_arbiter_if bus ();

  core_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Unwritten SRAM words read back as a fixed address pattern.
  logic [7:0] sram    [0:1023];
  logic       written [0:1023] = '{default: 1'b0};
  logic [7:0] rd_q = 8'h00;

  function automatic logic [7:0] pattern(input logic [9:0] a);
    return a[7:0] ^ 8'h76;
  endfunction

  // SRAM model: write at the edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      sram[bus.mem_addr]    <= bus.mem_wr_data;
      written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_re) begin
      rd_q <= written[bus.mem_addr] ? sram[bus.mem_addr] : pattern(bus.mem_addr);
    end
  end

  assign bus.mem_rd_data = rd_q;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int core, input logic [1:0] en,
                               input logic [9:0] addr, input logic [7:0] data);
    bus.enable_M[2*core +: 2]   = en;
    bus.addr_M[core*10 +: 10]   = addr;
    bus.wr_data_M[core*8 +: 8]  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 2'b00, 10'h000, 8'h00);
    settle();
    checkOutput("rst_cycle_ready", 32'(bus.ready_M), 32'h0);
    tick();
    reset = 1'b0;
  endtask

  // Check one cycle of a continuous-load stream: grant g now, ack p from last cycle.
  task automatic checkStream(input string name, input int k, input int g, input int p);
    logic [9:0] pa;
    checkOutput($sformatf("%s_addr_%0d", name, k), 32'(bus.mem_addr), 32'(10'h040 + 10'(g)));
    checkOutput($sformatf("%s_re_%0d", name, k), 32'(bus.mem_re), 32'h1);
    if (p >= 0) begin
      pa = 10'h040 + 10'(p);
      checkOutput($sformatf("%s_ready_%0d", name, k), 32'(bus.ready_M), 32'h1 << p);
      checkOutput($sformatf("%s_rd_%0d", name, k), bus.rd_data_M,
                  32'(pattern(pa)) << (8 * p));
    end else begin
      checkOutput($sformatf("%s_ready_%0d", name, k), 32'(bus.ready_M), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq4 [6];
    seq4 = '{0, 3, 0, 3, 0, 3};
    bus.enable_M  = '0;
    bus.addr_M    = '0;
    bus.wr_data_M = '0;
    reset = 1'b1;

    // Reset state and strobe gating while reset is high
    tick();
    tick();
    settle();
    checkOutput("rst_ready", 32'(bus.ready_M), 32'h0);
    checkOutput("rst_rd", bus.rd_data_M, 32'h0);
    applyStimulus(1, 2'b01, 10'h02A, 8'h00);
    settle();
    checkOutput("rst_re_gated", 32'(bus.mem_re), 32'h0);
    checkOutput("rst_we_gated", 32'(bus.mem_we), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1, 2'b00, 10'h000, 8'h00);
    settle();
    checkOutput("idle_re", 32'(bus.mem_re), 32'h0);
    checkOutput("idle_ready", 32'(bus.ready_M), 32'h0);

    // Single load by core1
    tick();
    applyStimulus(1, 2'b01, 10'h02A, 8'h00);
    settle();
    checkOutput("t1_re", 32'(bus.mem_re), 32'h1);
    checkOutput("t1_we", 32'(bus.mem_we), 32'h0);
    checkOutput("t1_addr", 32'(bus.mem_addr), 32'h02A);
    checkOutput("t1_ready_g", 32'(bus.ready_M), 32'h0);
    tick();
    checkOutput("t1_ready", 32'(bus.ready_M), 32'h2);
    checkOutput("t1_rd", bus.rd_data_M, 32'h0000_5C00);
    checkOutput("t1_no_regrant", 32'(bus.mem_re), 32'h0);
    tick();
    applyStimulus(1, 2'b00, 10'h000, 8'h00);
    settle();
    checkOutput("t1_after_ready", 32'(bus.ready_M), 32'h0);

    // Store by core0 then load of the same address by core2
    tick();
    applyStimulus(0, 2'b10, 10'h010, 8'hA5);
    settle();
    checkOutput("t2_we", 32'(bus.mem_we), 32'h1);
    checkOutput("t2_re", 32'(bus.mem_re), 32'h0);
    checkOutput("t2_addr", 32'(bus.mem_addr), 32'h010);
    checkOutput("t2_wdata", 32'(bus.mem_wr_data), 32'hA5);
    tick();
    applyStimulus(2, 2'b01, 10'h010, 8'h00);
    settle();
    checkOutput("t2_st_ready", 32'(bus.ready_M), 32'h1);
    checkOutput("t2_st_rd", bus.rd_data_M, 32'h0);
    checkOutput("t2_ld_re", 32'(bus.mem_re), 32'h1);
    checkOutput("t2_ld_addr", 32'(bus.mem_addr), 32'h010);
    tick();
    applyStimulus(0, 2'b00, 10'h000, 8'h00);
    settle();
    checkOutput("t2_ld_ready", 32'(bus.ready_M), 32'h4);
    checkOutput("t2_ld_rd", bus.rd_data_M, 32'h00A5_0000);
    checkOutput("t2_quiet_re", 32'(bus.mem_re), 32'h0);
    checkOutput("t2_quiet_we", 32'(bus.mem_we), 32'h0);
    tick();
    applyStimulus(2, 2'b00, 10'h000, 8'h00);

    // All four cores loading continuously from reset
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 2'b01, 10'h040 + 10'(i), 8'h00);
    settle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checkStream("t3", k, k % 4, (k > 0) ? (k - 1) % 4 : -1);
    end

    // Only cores 0 and 3 requesting: strict alternation
    doReset();
    applyStimulus(0, 2'b01, 10'h040, 8'h00);
    applyStimulus(3, 2'b01, 10'h043, 8'h00);
    settle();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      checkStream("t4", k, seq4[k], (k > 0) ? seq4[k-1] : -1);
    end

    // Reset during the response cycle drops the ack and restores priority
    doReset();
    applyStimulus(1, 2'b01, 10'h02A, 8'h00);
    settle();
    checkOutput("t5_grant_addr", 32'(bus.mem_addr), 32'h02A);
    tick();
    reset = 1'b1;
    settle();
    checkOutput("t5_ready_dropped", 32'(bus.ready_M), 32'h0);
    checkOutput("t5_rd_dropped", bus.rd_data_M, 32'h0);
    checkOutput("t5_re_in_reset", 32'(bus.mem_re), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(2, 2'b01, 10'h042, 8'h00);
    settle();
    checkOutput("t5_post_ready", 32'(bus.ready_M), 32'h0);
    checkOutput("t5_post_addr", 32'(bus.mem_addr), 32'h02A);
    checkOutput("t5_post_re", 32'(bus.mem_re), 32'h1);

    // Encoding 11 is never a request
    doReset();
    applyStimulus(2, 2'b11, 10'h055, 8'h77);
    settle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("t6_re_%0d", k), 32'(bus.mem_re), 32'h0);
      checkOutput($sformatf("t6_we_%0d", k), 32'(bus.mem_we), 32'h0);
      checkOutput($sformatf("t6_ready_%0d", k), 32'(bus.ready_M), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
